layer_mac_sequencer: RTL and testbench
======================================

Name: layer_mac_sequencer

Overview:
Sequences one shared vector_mac instance through every row of a weight matrix, producing one dot product per output neuron of a layer. On start it latches the full weight matrix and input vector, issues one mac start per row, and collects each mac result into a packed output vector. A sticky error flag and a watchdog report mac errors and a stalled mac. It sits between the layer control logic and the vector_mac; a top-level wrapper connects the two.

Parameters:
NEURONS, 4, number of matrix rows (output cells); must be >= 1
VECTOR_LEN, 5, elements per row and per input vector
A_CELL_WIDTH, 8, width of a weight element
B_CELL_WIDTH, 8, width of an input-vector element
RESULT_CELL_WIDTH, 10, width of one mac result / output cell
TIMEOUT, 64, maximum WAIT cycles per row before abort; must be >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
matrix  in  NEURONS*VECTOR_LEN*A_CELL_WIDTH  weights; row i at [i*VECTOR_LEN*A_CELL_WIDTH +: VECTOR_LEN*A_CELL_WIDTH]
vector  in  VECTOR_LEN*B_CELL_WIDTH  layer input vector
mac_start  out  1  start pulse to vector_mac
mac_a  out  VECTOR_LEN*A_CELL_WIDTH  current latched row
mac_b  out  VECTOR_LEN*B_CELL_WIDTH  latched input vector
mac_result  in  RESULT_CELL_WIDTH  vector_mac result
mac_valid  in  1  vector_mac result valid
mac_error  in  1  vector_mac error, qualified by mac_valid
result  out  NEURONS*RESULT_CELL_WIDTH  outputs; cell i at [i*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH]
valid  out  1  one-cycle pulse: result final
error  out  1  sticky: any mac_error or timeout in the current run
timeout  out  1  sticky: the run aborted by the watchdog
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; row index, watchdog, result, latched matrix and vector cleared. mac_start, valid, error, timeout and busy are 0. A reset mid-run aborts the run immediately. No valid pulse follows. Any later mac_valid is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: start=1 latches matrix and vector, clears result, error and timeout, sets row=0, and moves to ISSUE.
- ISSUE: mac_start=1 for exactly this cycle. mac_a = latched row[row]. Watchdog = 0. Next state WAIT.
- mac_a and mac_b are registered. They stay stable from ISSUE through the end of WAIT.
- WAIT, mac_valid=1:
  - result cell[row] <= mac_result; error |= mac_error.
  - If row==NEURONS-1, go to DONE. Otherwise row++ and go to ISSUE.
- WAIT, mac_valid=0:
  - Watchdog++.
  - If watchdog==TIMEOUT-1, set error=1 and timeout=1 and go to DONE. Remaining cells keep 0.
- DONE: valid=1 for one cycle, then IDLE. result, error and timeout hold until the next accepted start.
- mac_valid in IDLE, ISSUE or DONE is ignored.
- start outside IDLE is ignored; there is no queuing. start arriving in the same cycle as the DONE pulse is ignored. start is accepted from the following cycle.
- Latency: if the mac asserts valid in the L-th WAIT cycle (L>=1), then start edge to valid = 1 + NEURONS*(1+L) + 1 cycles.
- No arithmetic in this block. Results are stored bit-exact, with no extension or truncation.
- NEURONS=1 goes IDLE, ISSUE, WAIT, DONE.

Decomposition:
- Shared package/header holds:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - derived widths: ROW_WIDTH = VECTOR_LEN*A_CELL_WIDTH and ROW_IDX_WIDTH = clog2(NEURONS), minimum 1;
  - WDOG_WIDTH = clog2(TIMEOUT).
- One natural sub-module: mac_watchdog, a clearable counter with a terminal-count flag at TIMEOUT-1.
- vector_mac is not instantiated here.

Test Plan:
- Setup: a bench mac model computes sum(a_i*b_i) truncated to RESULT_CELL_WIDTH, with programmable latency L. Scenarios 1-4 use NEURONS=3, VECTOR_LEN=2, L=3.
- Scenario 1: rows {1,2},{3,4},{0,5}, vector {3,4}, start -> three mac_start pulses 4 cycles apart. result cells = 11, 25, 20. valid pulses 14 cycles after start. error=0.
- Scenario 2: same as scenario 1, but the model asserts mac_error on row 1 -> all cells written. error=1 and timeout=0 at the valid pulse. Both are cleared by the next start.
- Scenario 3: TIMEOUT=8; the model never answers row 1 -> cell 0 written, cells 1 and 2 = 0. error=1, timeout=1. valid pulses. busy drops the next cycle.
- Scenario 4: start pulsed again during WAIT, and matrix changed right after the first start -> second start ignored. Results match the originally latched matrix. Exactly one valid pulse.
- Scenario 5: rst asserted for 1 cycle mid-run during WAIT of row 1 -> all outputs 0 the next cycle, no valid pulse. A late mac_valid is ignored. A new start then completes normally.
- Scenario 6: NEURONS=1, L=1 -> valid 4 cycles after start, and the result equals the single dot product.

Source files
------------

// File: rtl/layer_mac_sequencer_pkg.sv
// Shared types and width helpers for the layer MAC sequencer and its watchdog.
package layer_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A counter or index always needs at least one bit, even for a single row.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int row_width(input int len, input int cell_width);
    return len * cell_width;
  endfunction

endpackage

// File: rtl/layer_mac_sequencer_watchdog.sv
// Clearable cycle counter that flags the last allowed WAIT cycle of a row.
module mac_watchdog #(
  parameter int TIMEOUT    = 64,
  parameter int WDOG_WIDTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WDOG_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == WDOG_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/layer_mac_sequencer.sv
// Walks one shared vector_mac over every weight row and gathers the dot products.
// Handshake: mac_start is a one-cycle request raised in ISSUE; mac_valid (and mac_error) count only in WAIT.
module layer_mac_sequencer
  import layer_mac_sequencer_pkg::*;
#(
  parameter int NEURONS           = 4,
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 10,
  parameter int TIMEOUT           = 64
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [NEURONS*VECTOR_LEN*A_CELL_WIDTH-1:0] matrix,
  input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]         vector,
  output logic                                      mac_start,
  output logic [VECTOR_LEN*A_CELL_WIDTH-1:0]         mac_a,
  output logic [VECTOR_LEN*B_CELL_WIDTH-1:0]         mac_b,
  input  logic [RESULT_CELL_WIDTH-1:0]               mac_result,
  input  logic                                      mac_valid,
  input  logic                                      mac_error,
  output logic [NEURONS*RESULT_CELL_WIDTH-1:0]       result,
  output logic                                      valid,
  output logic                                      error,
  output logic                                      timeout,
  output logic                                      busy
);

  localparam int ROW_WIDTH     = row_width(VECTOR_LEN, A_CELL_WIDTH);
  localparam int ROW_IDX_WIDTH = clog2_min1(NEURONS);
  localparam int WDOG_WIDTH    = clog2_min1(TIMEOUT);
  localparam logic [ROW_IDX_WIDTH-1:0] LAST_ROW = ROW_IDX_WIDTH'(NEURONS - 1);

  state_t                       state_q, state_d;
  logic [ROW_IDX_WIDTH-1:0]     row_q;
  logic [ROW_IDX_WIDTH-1:0]     next_row;
  logic [NEURONS*ROW_WIDTH-1:0] matrix_q;
  logic                         last_row;
  logic                         wdog_expired;

  assign next_row = row_q + 1'b1;
  assign last_row = (row_q == LAST_ROW);

  mac_watchdog #(
    .TIMEOUT    (TIMEOUT),
    .WDOG_WIDTH (WDOG_WIDTH)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == ISSUE),
    .enable   ((state_q == WAIT) && !mac_valid),
    .terminal (wdog_expired)
  );

  always_comb begin
    state_d   = state_q;
    mac_start = 1'b0;
    valid     = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        mac_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (mac_valid) state_d = last_row ? DONE : ISSUE;
        else if (wdog_expired) state_d = DONE;
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      matrix_q <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
      result   <= '0;
      error    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            matrix_q <= matrix;
            mac_a    <= matrix[ROW_WIDTH-1:0];
            mac_b    <= vector;
            result   <= '0;
            error    <= 1'b0;
            timeout  <= 1'b0;
            row_q    <= '0;
          end
        end
        WAIT: begin
          if (mac_valid) begin
            result[row_q*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] <= mac_result;
            error <= error | mac_error;
            // Preload the next row so mac_a is already stable when ISSUE pulses.
            if (!last_row) begin
              row_q <= next_row;
              mac_a <= matrix_q[next_row*ROW_WIDTH +: ROW_WIDTH];
            end
          end else if (wdog_expired) begin
            error   <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Bench for layer_mac_sequencer: a behavioural vector_mac with programmable latency and faults.
module tb_layer_mac_sequencer;

  localparam int N  = 3;
  localparam int V  = 2;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam int RW = 10;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: three rows, short watchdog.
  logic              start  = 1'b0;
  logic [N*V*AW-1:0] matrix = '0;
  logic [V*BW-1:0]   vector = '0;
  logic              mac_start;
  logic [V*AW-1:0]   mac_a;
  logic [V*BW-1:0]   mac_b;
  logic [RW-1:0]     mac_result = '0;
  logic              mac_valid  = 1'b0;
  logic              mac_error  = 1'b0;
  logic [N*RW-1:0]   result;
  logic              valid, error, timeout, busy;

  // Single-neuron instance.
  logic              start1  = 1'b0;
  logic [V*AW-1:0]   matrix1 = '0;
  logic [V*BW-1:0]   vector1 = '0;
  logic              mac_start1;
  logic [V*AW-1:0]   mac_a1;
  logic [V*BW-1:0]   mac_b1;
  logic [RW-1:0]     mac_result1 = '0;
  logic              mac_valid1  = 1'b0;
  logic              mac_error1  = 1'b0;
  logic [RW-1:0]     result1;
  logic              valid1, error1, timeout1, busy1;

  layer_mac_sequencer #(
    .NEURONS(N), .VECTOR_LEN(V), .A_CELL_WIDTH(AW), .B_CELL_WIDTH(BW),
    .RESULT_CELL_WIDTH(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .matrix(matrix), .vector(vector),
    .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(mac_result), .mac_valid(mac_valid), .mac_error(mac_error),
    .result(result), .valid(valid), .error(error), .timeout(timeout), .busy(busy)
  );

  layer_mac_sequencer #(
    .NEURONS(1), .VECTOR_LEN(V), .A_CELL_WIDTH(AW), .B_CELL_WIDTH(BW),
    .RESULT_CELL_WIDTH(RW), .TIMEOUT(64)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .matrix(matrix1), .vector(vector1),
    .mac_start(mac_start1), .mac_a(mac_a1), .mac_b(mac_b1),
    .mac_result(mac_result1), .mac_valid(mac_valid1), .mac_error(mac_error1),
    .result(result1), .valid(valid1), .error(error1), .timeout(timeout1), .busy(busy1)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [RW-1:0] exp_q[$];
  logic [1:0]    exp_flags_q[$];

  function automatic logic [RW-1:0] dot(input logic [V*AW-1:0] a, input logic [V*BW-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < V; i++) s += 32'(a[i*AW +: AW]) * 32'(b[i*BW +: BW]);
    return RW'(s);
  endfunction

  // vector_mac model for the main instance (latency lat >= 2 WAIT cycles).
  int lat      = 3;
  int mute_row = -1;
  int err_row  = -1;
  int m_row    = 0;
  int m_cur    = 0;
  int m_cnt    = 0;
  bit m_pend   = 1'b0;

  always @(posedge clk) begin
    mac_valid <= 1'b0;
    mac_error <= 1'b0;
    if (mac_start) begin
      m_cur  <= m_row;
      m_row  <= m_row + 1;
      m_pend <= 1'b1;
      m_cnt  <= 2;
    end else begin
      if (!busy) m_row <= 0;
      if (m_pend) begin
        if (m_cnt == lat) begin
          m_pend <= 1'b0;
          if (m_cur != mute_row) begin
            mac_valid  <= 1'b1;
            mac_result <= dot(mac_a, mac_b);
            mac_error  <= (m_cur == err_row);
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // Single-neuron model answers in the first WAIT cycle.
  always @(posedge clk) begin
    mac_valid1 <= 1'b0;
    if (mac_start1) begin
      mac_valid1  <= 1'b1;
      mac_result1 <= dot(mac_a1, mac_b1);
    end
  end

  int cyc       = 0;
  int valid_cnt = 0;
  int ms_cyc[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid) valid_cnt <= valid_cnt + 1;
    if (mac_start) ms_cyc.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r0a, r0b, r1a, r1b, r2a, r2b, va, vb);
    matrix = {8'(r2b), 8'(r2a), 8'(r1b), 8'(r1a), 8'(r0b), 8'(r0a)};
    vector = {8'(vb), 8'(va)};
  endtask

  task automatic push_expected();
    bit muted, err;
    muted = (mute_row >= 0);
    err   = muted || (err_row >= 0 && err_row < N && (!muted || err_row < mute_row));
    for (int i = 0; i < N; i++)
      exp_q.push_back((muted && i >= mute_row) ? RW'(0) : dot(matrix[i*V*AW +: V*AW], vector));
    exp_flags_q.push_back({err, muted});
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, inout int cycles, output bit got);
    got = 1'b0;
    while (!got && cycles < limit) begin
      step();
      cycles++;
      if (valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0 || mac_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy/valid/mac_start got %b%b%b expected 000", busy, valid, mac_start);
    end
    tests_run++;
    if (error !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: error/timeout got %b%b expected 00", error, timeout);
    end
    tests_run++;
    if (result !== '0 || mac_a !== '0 || mac_b !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: result %h mac_a %h mac_b %h expected all 0", result, mac_a, mac_b);
    end
    tests_run++;
    if (busy1 !== 1'b0 || result1 !== '0) begin
      tests_failed++;
      $display("FAIL reset_single: busy1 %b result1 %h expected 0", busy1, result1);
    end
  endtask

  task automatic test_basic();
    int cycles, base;
    bit got;
    logic [RW-1:0] e;
    logic [1:0] f;
    load(1, 2, 3, 4, 0, 5, 3, 4);
    mute_row = -1; err_row = -1;
    push_expected();
    base = ms_cyc.size();
    kick();
    cycles = 2;
    wait_valid(60, cycles, got);
    tests_run++;
    if (!got || cycles != 1 + N * (1 + lat) + 1) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d cycles (seen %0b) expected %0d", cycles, got, 1 + N * (1 + lat) + 1);
    end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (result[i*RW +: RW] !== e) begin
        tests_failed++;
        $display("FAIL basic_cell%0d: got %0d expected %0d", i, result[i*RW +: RW], e);
      end
    end
    f = exp_flags_q.pop_front();
    tests_run++;
    if ({error, timeout} !== f) begin
      tests_failed++;
      $display("FAIL basic_flags: error/timeout got %b%b expected %b", error, timeout, f);
    end
    tests_run++;
    if (ms_cyc.size() < base + 3 || ms_cyc[base+1] - ms_cyc[base] != 1 + lat
        || ms_cyc[base+2] - ms_cyc[base+1] != 1 + lat) begin
      tests_failed++;
      $display("FAIL basic_mac_start_spacing: got %0d pulses expected 3 spaced %0d apart", ms_cyc.size() - base, 1 + lat);
    end
  endtask

  task automatic test_mac_error();
    int cycles;
    bit got;
    logic [RW-1:0] e;
    logic [1:0] f;
    load(1, 2, 3, 4, 0, 5, 3, 4);
    step();
    for (int run = 0; run < 2; run++) begin
      err_row = (run == 0) ? 1 : -1;
      push_expected();
      kick();
      cycles = 2;
      if (run == 1) begin
        tests_run++;
        if (error !== 1'b0 || timeout !== 1'b0 || result !== '0) begin
          tests_failed++;
          $display("FAIL err_clear_on_start: error %b timeout %b result %h expected 0 0 0", error, timeout, result);
        end
      end
      wait_valid(60, cycles, got);
      tests_run++;
      if (!got) begin
        tests_failed++;
        $display("FAIL err_run%0d_valid: got no valid expected one within 60 cycles", run);
      end
      for (int i = 0; i < N; i++) begin
        e = exp_q.pop_front();
        tests_run++;
        if (result[i*RW +: RW] !== e) begin
          tests_failed++;
          $display("FAIL err_run%0d_cell%0d: got %0d expected %0d", run, i, result[i*RW +: RW], e);
        end
      end
      f = exp_flags_q.pop_front();
      tests_run++;
      if ({error, timeout} !== f) begin
        tests_failed++;
        $display("FAIL err_run%0d_flags: error/timeout got %b%b expected %b", run, error, timeout, f);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    int cycles;
    bit got;
    logic [RW-1:0] e;
    logic [1:0] f;
    load(1, 2, 3, 4, 0, 5, 3, 4);
    mute_row = 1; err_row = -1;
    push_expected();
    kick();
    cycles = 2;
    wait_valid(60, cycles, got);
    tests_run++;
    if (!got || cycles != 1 + (1 + lat) + (1 + TO) + 1) begin
      tests_failed++;
      $display("FAIL timeout_latency: got %0d cycles (seen %0b) expected %0d", cycles, got, 1 + (1 + lat) + (1 + TO) + 1);
    end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (result[i*RW +: RW] !== e) begin
        tests_failed++;
        $display("FAIL timeout_cell%0d: got %0d expected %0d", i, result[i*RW +: RW], e);
      end
    end
    f = exp_flags_q.pop_front();
    tests_run++;
    if ({error, timeout} !== f) begin
      tests_failed++;
      $display("FAIL timeout_flags: error/timeout got %b%b expected %b", error, timeout, f);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_busy_at_valid: got %b expected 1", busy);
    end
    step();
    tests_run++;
    if (busy !== 1'b0 || timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_after: busy %b timeout %b expected 0 1", busy, timeout);
    end
    mute_row = -1;
  endtask

  task automatic test_back_to_back();
    int cycles, vc0;
    bit got;
    logic [RW-1:0] e;
    load(1, 2, 3, 4, 0, 5, 3, 4);
    push_expected();
    vc0 = valid_cnt;
    kick();
    matrix = '1;
    step();
    step();
    kick();
    cycles = 5;
    wait_valid(60, cycles, got);
    tests_run++;
    if (!got || cycles != 1 + N * (1 + lat) + 1) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d cycles (seen %0b) expected %0d", cycles, got, 1 + N * (1 + lat) + 1);
    end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (result[i*RW +: RW] !== e) begin
        tests_failed++;
        $display("FAIL b2b_cell%0d: got %0d expected %0d", i, result[i*RW +: RW], e);
      end
    end
    void'(exp_flags_q.pop_front());
    repeat (10) step();
    tests_run++;
    if (valid_cnt - vc0 != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_single_run: got %0d valid pulses busy %b expected 1 pulse busy 0", valid_cnt - vc0, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int cycles, base, n, vc0;
    bit got;
    logic [RW-1:0] e;
    logic [1:0] f;
    load(1, 2, 3, 4, 0, 5, 3, 4);
    base = ms_cyc.size();
    kick();
    n = 0;
    while (ms_cyc.size() < base + 2 && n < 40) begin
      step();
      n++;
    end
    tests_run++;
    if (ms_cyc.size() < base + 2) begin
      tests_failed++;
      $display("FAIL midrst_row1_issue: got %0d mac_start pulses expected 2", ms_cyc.size() - base);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if ({result, valid, error, timeout, busy, mac_start, mac_a, mac_b} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: result %h v%b e%b t%b b%b ms%b a %h b %h expected all 0",
               result, valid, error, timeout, busy, mac_start, mac_a, mac_b);
    end
    vc0 = valid_cnt;
    repeat (8) step();
    tests_run++;
    if (valid_cnt != vc0 || result !== '0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_late_ignored: valid pulses %0d result %h busy %b expected 0 0 0", valid_cnt - vc0, result, busy);
    end
    load(2, 2, 1, 1, 4, 0, 5, 6);
    push_expected();
    kick();
    cycles = 2;
    wait_valid(60, cycles, got);
    tests_run++;
    if (!got || cycles != 1 + N * (1 + lat) + 1) begin
      tests_failed++;
      $display("FAIL midrst_rerun_latency: got %0d cycles (seen %0b) expected %0d", cycles, got, 1 + N * (1 + lat) + 1);
    end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      tests_run++;
      if (result[i*RW +: RW] !== e) begin
        tests_failed++;
        $display("FAIL midrst_rerun_cell%0d: got %0d expected %0d", i, result[i*RW +: RW], e);
      end
    end
    f = exp_flags_q.pop_front();
    tests_run++;
    if ({error, timeout} !== f) begin
      tests_failed++;
      $display("FAIL midrst_rerun_flags: error/timeout got %b%b expected %b", error, timeout, f);
    end
    step();
  endtask

  task automatic test_single_neuron();
    int cycles;
    bit got;
    logic [RW-1:0] e;
    for (int run = 0; run < 2; run++) begin
      matrix1 = (run == 0) ? {8'd9, 8'd7} : {8'd255, 8'd255};
      vector1 = (run == 0) ? {8'd20, 8'd10} : {8'd255, 8'd255};
      exp_q.push_back(dot(matrix1, vector1));
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      cycles = 2;
      got = 1'b0;
      while (!got && cycles < 20) begin
        step();
        cycles++;
        if (valid1) got = 1'b1;
      end
      tests_run++;
      if (!got || cycles != 4) begin
        tests_failed++;
        $display("FAIL single_run%0d_latency: got %0d cycles (seen %0b) expected 4", run, cycles, got);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (result1 !== e || error1 !== 1'b0 || timeout1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_run%0d_result: got %0d err %b to %b expected %0d 0 0", run, result1, error1, timeout1, e);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mac_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_run();
    test_single_neuron();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
